// File: rtl/i2c_pkg.sv
// Shared types and constants for the HDMI-transmitter config responder.
package i2c_pkg;

  localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h39;
  localparam logic       RW_WRITE         = 1'b0;
  localparam logic       RW_READ          = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ACK_A,
    ST_SUB,
    ST_ACK_S,
    ST_WDATA,
    ST_ACK_W,
    ST_RDATA,
    ST_RACK,
    ST_IGNORE
  } state_t;

endpackage

// File: rtl/i2c_hdmi_cfg_responder_if.sv
// Open-drain I2C bus as seen by the config master and the target.
interface i2c_hdmi_cfg_responder_if;
  logic I2C_SCLK;
  logic I2C_SDAT_IN;
  logic I2C_SDAT_OE;

  modport master (output I2C_SCLK, output I2C_SDAT_IN, input I2C_SDAT_OE);
  modport slave  (input I2C_SCLK, input I2C_SDAT_IN, output I2C_SDAT_OE);
endinterface

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronisers with SCL edge and START/STOP detection.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic iCLK,
  input  logic iRST_N,
  input  logic scl_raw,
  input  logic sda_raw,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sr;
  logic [SYNC_STAGES-1:0] sda_sr;
  logic                   scl_q;
  logic                   sda_q;
  logic                   scl;

  // Idle-high reset value keeps reset release from looking like a bus edge.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      scl_sr <= '1;
      sda_sr <= '1;
      scl_q  <= 1'b1;
      sda_q  <= 1'b1;
    end else begin
      scl_sr <= {scl_sr[SYNC_STAGES-2:0], scl_raw};
      sda_sr <= {sda_sr[SYNC_STAGES-2:0], sda_raw};
      scl_q  <= scl_sr[SYNC_STAGES-1];
      sda_q  <= sda_sr[SYNC_STAGES-1];
    end
  end

  assign scl      = scl_sr[SYNC_STAGES-1];
  assign sda      = sda_sr[SYNC_STAGES-1];
  assign scl_rise = scl & ~scl_q;
  assign scl_fall = ~scl & scl_q;

  // SCL must be high in both samples, so an SDA edge coinciding with an SCL edge is data.
  assign start_det = scl & scl_q & sda_q & ~sda;
  assign stop_det  = scl & scl_q & ~sda_q & sda;

endmodule

// File: rtl/i2c_hdmi_cfg_responder.sv
// I2C target with a 256x8 register file, write-notify strobe and local read port.
module i2c_hdmi_cfg_responder
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = DEV_ADDR_DEFAULT,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                          iCLK,
  input  logic                          iRST_N,
  i2c_hdmi_cfg_responder_if.slave       bus,
  input  logic [7:0]                    REG_RADDR,
  output logic [7:0]                    REG_RDATA,
  output logic                          WR_STROBE,
  output logic [7:0]                    WR_ADDR,
  output logic [7:0]                    WR_DATA,
  output logic                          BUSY
);

  state_t      state, state_n;
  logic [3:0]  bit_cnt, bit_cnt_n;
  logic [7:0]  shreg, shreg_n;
  logic [7:0]  ptr, ptr_n;
  logic [7:0]  tx, tx_n;
  logic        oe, oe_n;
  logic        busy, busy_n;
  logic        wr_en;
  logic [7:0]  byte_in;
  logic [7:0]  mem [256];

  logic sda, scl_rise, scl_fall, start_det, stop_det;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .iCLK      (iCLK),
    .iRST_N    (iRST_N),
    .scl_raw   (bus.I2C_SCLK),
    .sda_raw   (bus.I2C_SDAT_IN),
    .sda       (sda),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  assign byte_in = {shreg[6:0], sda};

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    ptr_n     = ptr;
    tx_n      = tx;
    oe_n      = oe;
    busy_n    = busy;
    wr_en     = 1'b0;
    if (start_det) begin
      state_n   = ST_ADDR;
      bit_cnt_n = 4'd0;
      oe_n      = 1'b0;
      busy_n    = 1'b0;
    end else if (stop_det) begin
      state_n   = ST_IDLE;
      bit_cnt_n = 4'd0;
      oe_n      = 1'b0;
      busy_n    = 1'b0;
    end else begin
      case (state)
        ST_ADDR, ST_SUB, ST_WDATA: if (scl_rise) begin
          shreg_n   = byte_in;
          bit_cnt_n = bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) begin
            bit_cnt_n = 4'd0;
            if (state == ST_ADDR) begin
              if (shreg[6:0] == DEV_ADDR && shreg[6:0] != 7'h00) begin
                state_n = ST_ACK_A;
                busy_n  = 1'b1;
                tx_n    = mem[ptr];
              end else begin
                state_n = ST_IGNORE;
              end
            end else if (state == ST_SUB) begin
              ptr_n   = byte_in;
              state_n = ST_ACK_S;
            end else begin
              wr_en   = 1'b1;
              ptr_n   = ptr + 8'd1;
              state_n = ST_ACK_W;
            end
          end
        end
        // First SCL fall drives the ACK, second one ends the 9th clock.
        ST_ACK_A, ST_ACK_S, ST_ACK_W: if (scl_fall) begin
          if (!oe) begin
            oe_n = 1'b1;
          end else begin
            oe_n = 1'b0;
            if (state != ST_ACK_A) begin
              state_n = ST_WDATA;
            end else if (shreg[0] == RW_WRITE) begin
              state_n = ST_SUB;
            end else begin
              state_n = ST_RDATA;
              oe_n    = ~tx[7];
            end
          end
        end
        ST_RDATA: begin
          if (scl_rise) begin
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              oe_n      = 1'b0;
              bit_cnt_n = 4'd0;
              state_n   = ST_RACK;
            end else begin
              oe_n = ~tx[3'd7 - bit_cnt[2:0]];
            end
          end
        end
        ST_RACK: if (scl_rise) begin
          if (!sda) begin
            ptr_n   = ptr + 8'd1;
            tx_n    = mem[ptr + 8'd1];
            state_n = ST_RDATA;
          end else begin
            state_n = ST_IGNORE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state     <= ST_IDLE;
      bit_cnt   <= 4'd0;
      shreg     <= 8'h00;
      ptr       <= 8'h00;
      tx        <= 8'h00;
      oe        <= 1'b0;
      busy      <= 1'b0;
      WR_STROBE <= 1'b0;
      WR_ADDR   <= 8'h00;
      WR_DATA   <= 8'h00;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      shreg     <= shreg_n;
      ptr       <= ptr_n;
      tx        <= tx_n;
      oe        <= oe_n;
      busy      <= busy_n;
      WR_STROBE <= wr_en;
      if (wr_en) begin
        WR_ADDR <= ptr;
        WR_DATA <= byte_in;
      end
    end
  end

  // Non-blocking write means a same-cycle local read sees the old value.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      REG_RDATA <= 8'h00;
    end else begin
      if (wr_en) mem[ptr] <= byte_in;
      REG_RDATA <= mem[REG_RADDR];
    end
  end

  assign bus.I2C_SDAT_OE = oe;
  assign BUSY            = busy;

endmodule

// File: tb/tb_i2c_hdmi_cfg_responder.sv
// Bus-level bench: I2C master tasks, register-file model and write-strobe scoreboard.
module tb_i2c_hdmi_cfg_responder;
  localparam int Q = 50;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       sda_m = 1'b1;
  logic [7:0] raddr = 8'h00;
  logic [7:0] rdata, waddr, wdata;
  logic       strobe, busy;

  i2c_hdmi_cfg_responder_if bus();
  assign bus.I2C_SDAT_IN = sda_m & ~bus.I2C_SDAT_OE;

  i2c_hdmi_cfg_responder dut (
    .iCLK      (clk),
    .iRST_N    (rst_n),
    .bus       (bus.slave),
    .REG_RADDR (raddr),
    .REG_RDATA (rdata),
    .WR_STROBE (strobe),
    .WR_ADDR   (waddr),
    .WR_DATA   (wdata),
    .BUSY      (busy)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  model_mem [256];
  logic [7:0]  model_ptr;
  logic [15:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest expected {addr,data}.
  initial begin : monitor
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (strobe === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL wr_strobe unexpected got %0h/%0h want none", waddr, wdata);
        end else begin
          e = exp_q.pop_front();
          if ({waddr, wdata} !== e) begin
            errors++;
            $display("FAIL wr_strobe got %0h/%0h want %0h/%0h", waddr, wdata, e[15:8], e[7:0]);
          end
        end
      end
    end
  end

  task automatic bit_out(input logic b, output logic s);
    sda_m = b;         #Q;
    bus.I2C_SCLK = 1'b1; #Q;
    s = bus.I2C_SDAT_IN; #Q;
    bus.I2C_SCLK = 1'b0; #Q;
  endtask

  task automatic start_c();
    sda_m = 1'b1;        #Q;
    bus.I2C_SCLK = 1'b1; #Q;
    sda_m = 1'b0;        #Q;
    bus.I2C_SCLK = 1'b0; #Q;
  endtask

  task automatic stop_c();
    sda_m = 1'b0;        #Q;
    bus.I2C_SCLK = 1'b1; #Q;
    sda_m = 1'b1;        #(2*Q);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string name);
    logic s;
    for (int i = 7; i >= 0; i--) bit_out(b[i], s);
    bit_out(1'b1, s);
    chk(name, !s, exp_ack);
  endtask

  task automatic read_byte(input logic m_ack, input logic [7:0] exp, input string name);
    logic [7:0] got;
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_out(1'b1, s);
      got[i] = s;
    end
    chk(name, got, exp);
    bit_out(!m_ack, s);
  endtask

  task automatic wr_txn(input logic [7:0] sub, input logic [7:0] data[$]);
    start_c();
    send_byte(8'h72, 1'b1, "ack_addr_w");
    chk("busy_after_match", busy, 1);
    send_byte(sub, 1'b1, "ack_sub");
    model_ptr = sub;
    foreach (data[k]) begin
      exp_q.push_back({model_ptr, data[k]});
      model_mem[model_ptr] = data[k];
      model_ptr = model_ptr + 8'd1;
      send_byte(data[k], 1'b1, "ack_data");
    end
    stop_c();
    chk("busy_after_stop", busy, 0);
    chk("wr_queue_drained", exp_q.size(), 0);
  endtask

  task automatic rd_txn(input logic use_sub, input logic [7:0] sub, input int n);
    start_c();
    if (use_sub) begin
      send_byte(8'h72, 1'b1, "ack_addr_w");
      send_byte(sub, 1'b1, "ack_sub");
      model_ptr = sub;
      start_c();
    end
    send_byte(8'h73, 1'b1, "ack_addr_r");
    for (int k = 0; k < n; k++) begin
      read_byte(k != n - 1, model_mem[model_ptr], "rd_data");
      if (k != n - 1) model_ptr = model_ptr + 8'd1;
    end
    chk("sda_released_after_nack", bus.I2C_SDAT_OE, 0);
    chk("busy_before_stop", busy, 1);
    stop_c();
    chk("busy_after_stop", busy, 0);
  endtask

  initial begin : main
    logic [7:0] dq [$];
    logic       s;
    logic [7:0] sub;
    bus.I2C_SCLK = 1'b1;
    for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
    model_ptr = 8'h00;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_oe", bus.I2C_SDAT_OE, 0);
    chk("rst_busy", busy, 0);
    chk("rst_strobe", strobe, 0);
    chk("rst_wr_addr", waddr, 0);
    chk("rst_wr_data", wdata, 0);
    chk("rst_rdata", rdata, 0);
    #30 rst_n = 1'b1;

    // Basic single write and local read-back
    dq = {8'h03};
    wr_txn(8'h98, dq);
    @(negedge clk) raddr = 8'h98;
    @(negedge clk) chk("local_read_98", rdata, 8'h03);
    #3;

    // Foreign address and general call are never acknowledged
    start_c();
    send_byte(8'h70, 1'b0, "nack_addr_70");
    chk("busy_foreign", busy, 0);
    send_byte(8'h98, 1'b0, "ignored_byte0");
    send_byte(8'h03, 1'b0, "ignored_byte1");
    stop_c();
    start_c();
    send_byte(8'h00, 1'b0, "nack_general_call");
    stop_c();

    // Pointer wrap 0xFF -> 0x00
    dq = {8'hAA, 8'h55};
    wr_txn(8'hFF, dq);

    // Write then repeated-start read with master ACK then NACK
    dq = {8'h30};
    wr_txn(8'h15, dq);
    rd_txn(1'b1, 8'h15, 2);

    // STOP inside a data byte discards it
    start_c();
    send_byte(8'h72, 1'b1, "ack_addr_w");
    send_byte(8'h40, 1'b1, "ack_sub");
    model_ptr = 8'h40;
    for (int i = 0; i < 4; i++) bit_out(1'b1, s);
    stop_c();
    chk("busy_partial_stop", busy, 0);
    dq = {8'h5C};
    wr_txn(8'h41, dq);
    rd_txn(1'b0, 8'h00, 1);

    // Reset during ACK_S
    start_c();
    send_byte(8'h72, 1'b1, "ack_addr_w");
    sub = 8'h77;
    for (int i = 7; i >= 0; i--) bit_out(sub[i], s);
    sda_m = 1'b1; #Q;
    bus.I2C_SCLK = 1'b1; #(Q/2);
    chk("ack_sub_before_reset", bus.I2C_SDAT_OE, 1);
    rst_n = 1'b0;
    #1;
    chk("reset_oe_async", bus.I2C_SDAT_OE, 0);
    chk("reset_busy", busy, 0);
    chk("reset_wr_data", wdata, 0);
    #(Q/2 - 1);
    bus.I2C_SCLK = 1'b0; #Q;
    chk("reset_rdata", rdata, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
    model_ptr = 8'h00;
    send_byte(8'h72, 1'b0, "ignored_after_reset0");
    send_byte(8'h5A, 1'b0, "ignored_after_reset1");
    stop_c();
    chk("busy_after_reset_traffic", busy, 0);

    // Randomised mix of writes and reads
    repeat (8) begin
      dq.delete();
      repeat ($urandom_range(1, 3)) dq.push_back(8'($urandom));
      sub = 8'($urandom);
      if ($urandom_range(0, 1) == 0) wr_txn(sub, dq);
      else rd_txn($urandom_range(0, 1) == 1, sub, $urandom_range(1, 3));
    end

    // Full register-file sweep through the local read port
    for (int a = 0; a < 256; a++) begin
      @(negedge clk) raddr = 8'(a);
      @(negedge clk) chk($sformatf("local_read_%02h", a), rdata, model_mem[a]);
    end
    chk("wr_queue_final", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
